eq_access_ctrl: RTL and testbench

// - Front-end arbiter directly upstream of the 4-bank Event Queue; the only block driving its EV_in/op/cs.
// - Buffers insert requests from gate-evaluation logic in a small FIFO; serves extract requests from the scheduler.
// - Issues one-cycle EQ commands only when EQ status allows; returns extracted events plus a time-order check.

---
 rtl/eq_access_ctrl.sv | 139 +++++++++++++
 tb/tb_eq_access_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_access_ctrl.sv
// Front-end arbiter for the 4-bank Event Queue: buffers inserts in a small FIFO,
// serves scheduler extracts, and issues one-cycle EQ commands with a settle gap.
//
// state | meaning
// IDLE  | waiting; arbitrate between buffered insert and pending extract
// INS   | eq_cs high, insert command with FIFO head on eq_ev_in
// EXT   | eq_cs high, extract command; EQ head captured on exit
// GAP   | eq_cs low for one cycle so EQ busy/len settle before next decision
module eq_access_ctrl #(
  parameter int data_wd     = 32,
  parameter int q_add_wd    = 5,
  parameter int fifo_add_wd = 2,
  parameter int hi          = 15,
  parameter int lo          = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [data_wd-1:0]     ins_ev,
  input  logic                   ins_vld,
  output logic                   ins_rdy,
  input  logic                   ext_req,
  output logic [data_wd-1:0]     out_ev,
  output logic                   out_vld,
  output logic [data_wd-1:0]     eq_ev_in,
  output logic                   eq_op,
  output logic                   eq_cs,
  input  logic [data_wd-1:0]     eq_ev_out,
  input  logic                   eq_dv,
  input  logic                   eq_full,
  input  logic                   eq_empty,
  input  logic                   eq_busy_rd,
  input  logic                   eq_busy_wr,
  output logic [fifo_add_wd:0]   pend_cnt,
  output logic                   err_order
);

  localparam int fifo_depth = 1 << fifo_add_wd;

  localparam logic INSERT_CMD  = 1'b0;
  localparam logic EXTRACT_CMD = 1'b1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INS  = 2'd1;
  localparam logic [1:0] EXT  = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  if (hi >= data_wd || lo > hi || q_add_wd < 1) begin : g_bad_params
    $error("eq_access_ctrl: inconsistent TIME field or EQ length width");
  end

  logic [1:0]             state, state_nxt;
  logic [data_wd-1:0]     fifo_mem [fifo_depth];
  logic [fifo_add_wd-1:0] wr_ptr, rd_ptr;
  logic [fifo_add_wd:0]   cnt;
  logic                   ext_pend;
  logic                   last_ext;
  logic [hi-lo:0]         last_time;
  logic                   push, pop;
  logic                   ins_ok, ext_ok;
  logic                   grant_ins, grant_ext;

  // Count can only reach depth exactly, so its MSB alone marks full.
  assign ins_rdy  = !cnt[fifo_add_wd];
  assign pend_cnt = cnt;
  assign push     = ins_vld && ins_rdy;
  assign pop      = grant_ins;

  assign ins_ok = (cnt != '0) && !eq_full && !eq_busy_wr;
  assign ext_ok = ext_pend && !eq_empty && eq_dv && !eq_busy_rd;

  // last_ext only flips on contested grants, so contention alternates.
  assign grant_ext = (state == IDLE) && ext_ok && (!ins_ok || !last_ext);
  assign grant_ins = (state == IDLE) && ins_ok && (!ext_ok || last_ext);

  assign eq_cs = (state == INS) || (state == EXT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_ext)      state_nxt = EXT;
        else if (grant_ins) state_nxt = INS;
      end
      INS:     state_nxt = GAP;
      EXT:     state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ins_ev;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      ext_pend  <= 1'b0;
      last_ext  <= 1'b0;
      eq_ev_in  <= '0;
      eq_op     <= INSERT_CMD;
      out_ev    <= '0;
      out_vld   <= 1'b0;
      last_time <= '0;
      err_order <= 1'b0;
    end else begin
      state <= state_nxt;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;

      if (grant_ext)    ext_pend <= 1'b0;
      else if (ext_req) ext_pend <= 1'b1;

      if (ins_ok && ext_ok && (state == IDLE)) last_ext <= grant_ext;

      if (grant_ins) begin
        eq_ev_in <= fifo_mem[rd_ptr];
        eq_op    <= INSERT_CMD;
      end else if (grant_ext) begin
        eq_op    <= EXTRACT_CMD;
      end

      if (state == EXT) out_ev <= eq_ev_out;
      out_vld <= (state == EXT);

      if (out_vld) begin
        if (out_ev[hi:lo] < last_time) err_order <= 1'b1;
        last_time <= out_ev[hi:lo];
      end
    end
  end

endmodule

// File: tb/tb_eq_access_ctrl.sv
// Directed bench for eq_access_ctrl; EQ status and head are driven by hand.
module tb_eq_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins_ev;
  logic        ins_vld;
  logic        ins_rdy;
  logic        ext_req;
  logic [31:0] out_ev;
  logic        out_vld;
  logic [31:0] eq_ev_in;
  logic        eq_op;
  logic        eq_cs;
  logic [31:0] eq_ev_out;
  logic        eq_dv, eq_full, eq_empty, eq_busy_rd, eq_busy_wr;
  logic [2:0]  pend_cnt;
  logic        err_order;

  int checks = 0;
  int errors = 0;

  localparam logic OP_INS = 1'b0;
  localparam logic OP_EXT = 1'b1;

  eq_access_ctrl dut (
    .clk(clk), .rst(rst),
    .ins_ev(ins_ev), .ins_vld(ins_vld), .ins_rdy(ins_rdy),
    .ext_req(ext_req), .out_ev(out_ev), .out_vld(out_vld),
    .eq_ev_in(eq_ev_in), .eq_op(eq_op), .eq_cs(eq_cs),
    .eq_ev_out(eq_ev_out), .eq_dv(eq_dv), .eq_full(eq_full),
    .eq_empty(eq_empty), .eq_busy_rd(eq_busy_rd), .eq_busy_wr(eq_busy_wr),
    .pend_cnt(pend_cnt), .err_order(err_order)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  logic [31:0] q3 [3];
  logic [31:0] burst [5];

  initial begin
    q3[0] = 32'h0C00_0002; q3[1] = 32'h0C00_0005; q3[2] = 32'h0C00_0009;
    for (int i = 0; i < 5; i++) burst[i] = 32'h2000_0010 + 32'(i);

    rst = 1'b0; ins_ev = '0; ins_vld = 1'b0; ext_req = 1'b0;
    eq_ev_out = '0; eq_dv = 1'b0; eq_full = 1'b0; eq_empty = 1'b1;
    eq_busy_rd = 1'b0; eq_busy_wr = 1'b0;
    #12;
    chk("rst_cs", eq_cs, 0);
    chk("rst_op", eq_op, OP_INS);
    chk("rst_ev_in", eq_ev_in, 0);
    chk("rst_out_ev", out_ev, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_err", err_order, 0);
    chk("rst_rdy", ins_rdy, 1);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // three inserts, one per cycle
    ins_vld = 1'b1; ins_ev = 32'h1111_0005;
    tick();
    ins_ev = 32'h1111_0002;
    chk("t1_pend1", pend_cnt, 1);
    chk("t1_cs_c1", eq_cs, 0);
    tick();
    ins_ev = 32'h1111_0009;
    chk("t1_cs_a", eq_cs, 1);
    chk("t1_op_a", eq_op, OP_INS);
    chk("t1_ev_a", eq_ev_in, 32'h1111_0005);
    chk("t1_pend_a", pend_cnt, 1);
    chk("t1_rdy", ins_rdy, 1);
    tick();
    ins_vld = 1'b0;
    chk("t1_gap_cs", eq_cs, 0);
    chk("t1_pend2", pend_cnt, 2);
    tick();
    chk("t1_idle_cs", eq_cs, 0);
    tick();
    chk("t1_cs_b", eq_cs, 1);
    chk("t1_ev_b", eq_ev_in, 32'h1111_0002);
    chk("t1_pend_b", pend_cnt, 1);
    tick(); tick(); tick();
    chk("t1_cs_c", eq_cs, 1);
    chk("t1_ev_c", eq_ev_in, 32'h1111_0009);
    chk("t1_pend_c", pend_cnt, 0);
    tick(); tick();
    chk("t1_hold_ev", eq_ev_in, 32'h1111_0009);

    // back-pressure with EQ write busy
    eq_busy_wr = 1'b1; ins_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ins_ev = burst[i];
      tick();
    end
    ins_ev = burst[4];
    chk("t2_pend4", pend_cnt, 4);
    chk("t2_rdy0", ins_rdy, 0);
    chk("t2_cs0", eq_cs, 0);
    tick();
    eq_busy_wr = 1'b0;
    chk("t2_pend_hold", pend_cnt, 4);
    tick();
    chk("t2_cs_0", eq_cs, 1);
    chk("t2_ev_0", eq_ev_in, burst[0]);
    chk("t2_rdy1", ins_rdy, 1);
    chk("t2_pend3", pend_cnt, 3);
    tick();
    ins_vld = 1'b0;
    chk("t2_pend_push", pend_cnt, 4);
    tick(); tick();
    chk("t2_ev_1", eq_ev_in, burst[1]);
    chk("t2_cs_1", eq_cs, 1);
    for (int k = 2; k < 5; k++) begin
      tick(); tick(); tick();
      chk($sformatf("t2_cs_%0d", k), eq_cs, 1);
      chk($sformatf("t2_ev_%0d", k), eq_ev_in, burst[k]);
    end
    chk("t2_pend_end", pend_cnt, 0);
    tick(); tick();

    // three extracts from an EQ holding {2,5,9}
    eq_empty = 1'b0; eq_dv = 1'b1; eq_ev_out = q3[0];
    for (int k = 0; k < 3; k++) begin
      ext_req = 1'b1;
      tick();
      ext_req = 1'b0;
      chk($sformatf("t3_cs_early_%0d", k), eq_cs, 0);
      tick();
      chk($sformatf("t3_cs_%0d", k), eq_cs, 1);
      chk($sformatf("t3_op_%0d", k), eq_op, OP_EXT);
      tick();
      chk($sformatf("t3_vld_%0d", k), out_vld, 1);
      chk($sformatf("t3_ev_%0d", k), out_ev, q3[k]);
      if (k < 2) eq_ev_out = q3[k+1];
      tick();
      chk($sformatf("t3_vld_off_%0d", k), out_vld, 0);
    end
    chk("t3_err", err_order, 0);
    chk("t3_hold_out", out_ev, q3[2]);

    // contention alternation
    do_reset();
    eq_ev_out = 32'h0D00_0001;
    ins_vld = 1'b1; ins_ev = 32'h3000_0030; ext_req = 1'b1;
    tick();
    ins_vld = 1'b0; ext_req = 1'b0;
    tick();
    chk("t4_first_op", eq_op, OP_EXT);
    chk("t4_first_cs", eq_cs, 1);
    chk("t4_pend", pend_cnt, 1);
    tick();
    chk("t4_vld", out_vld, 1);
    chk("t4_out", out_ev, 32'h0D00_0001);
    tick(); tick();
    chk("t4_second_op", eq_op, OP_INS);
    chk("t4_second_cs", eq_cs, 1);
    chk("t4_second_ev", eq_ev_in, 32'h3000_0030);
    ins_vld = 1'b1; ins_ev = 32'h3000_0031; ext_req = 1'b1;
    tick();
    ins_vld = 1'b0; ext_req = 1'b0;
    tick(); tick();
    chk("t4_alt_op", eq_op, OP_INS);
    chk("t4_alt_cs", eq_cs, 1);
    chk("t4_alt_ev", eq_ev_in, 32'h3000_0031);
    tick(); tick(); tick();
    chk("t4_after_op", eq_op, OP_EXT);
    chk("t4_after_cs", eq_cs, 1);
    tick();
    chk("t4_after_vld", out_vld, 1);
    tick();

    // extract on empty EQ, then insert 7, then out-of-order 3
    do_reset();
    eq_empty = 1'b1; eq_dv = 1'b0; eq_ev_out = '0;
    ext_req = 1'b1;
    tick();
    ext_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t5_nocs_%0d", k), eq_cs, 0);
      tick();
    end
    ins_vld = 1'b1; ins_ev = 32'h5000_0007;
    tick();
    ins_vld = 1'b0;
    tick();
    chk("t5_ins_cs", eq_cs, 1);
    chk("t5_ins_op", eq_op, OP_INS);
    chk("t5_ins_ev", eq_ev_in, 32'h5000_0007);
    eq_empty = 1'b0; eq_dv = 1'b1; eq_ev_out = 32'h5000_0007;
    tick(); tick(); tick();
    chk("t5_ext_cs", eq_cs, 1);
    chk("t5_ext_op", eq_op, OP_EXT);
    tick();
    chk("t5_vld7", out_vld, 1);
    chk("t5_out7", out_ev, 32'h5000_0007);
    eq_ev_out = 32'h5000_0003;
    tick();
    chk("t5_err0", err_order, 0);
    ext_req = 1'b1;
    tick();
    ext_req = 1'b0;
    tick(); tick();
    chk("t5_vld3", out_vld, 1);
    chk("t5_out3", out_ev, 32'h5000_0003);
    tick();
    chk("t5_err1", err_order, 1);
    tick(); tick();
    chk("t5_err_sticky", err_order, 1);

    // reset in the middle of an extract
    eq_busy_wr = 1'b1; ins_vld = 1'b1; ins_ev = 32'h6000_0050;
    tick();
    ins_ev = 32'h6000_0051;
    tick();
    ins_vld = 1'b0;
    chk("t6_pend2", pend_cnt, 2);
    ext_req = 1'b1;
    tick();
    ext_req = 1'b0;
    tick();
    chk("t6_ext_cs", eq_cs, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_cs_drop", eq_cs, 0);
    chk("t6_pend0", pend_cnt, 0);
    chk("t6_rdy", ins_rdy, 1);
    chk("t6_vld", out_vld, 0);
    chk("t6_err_clr", err_order, 0);
    eq_busy_wr = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t6_quiet_cs_%0d", k), eq_cs, 0);
      chk($sformatf("t6_quiet_vld_%0d", k), out_vld, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
